// File: rtl/seq_detect_hit_logger.sv
// Logs the bit index of each 11011 detection into a small first-word-fall-through FIFO,
// with a saturating hit count and a sticky overflow flag.
module seq_detect_hit_logger #(
  parameter int POS_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hit,
  input  logic                     clr,
  input  logic                     rd_en,
  output logic [POS_W-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [POS_W-1:0] bit_idx;
  logic [POS_W-1:0] mem [DEPTH];
  logic [POS_W-1:0] last_pop;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             push;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign pop   = rd_en & ~empty;
  assign push  = hit & (~full | pop);

  // While empty, present the most recently popped value instead of a stale slot.
  assign rd_data = empty ? last_pop : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= bit_idx - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_pop <= '0;
      hit_cnt  <= '0;
      ovf      <= 1'b0;
    end else if (clr) begin
      bit_idx  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_pop <= '0;
      hit_cnt  <= '0;
      ovf      <= 1'b0;
    end else begin
      bit_idx <= bit_idx + 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Dropped detections still count toward hit_cnt.
      if (hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (hit && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_hit_logger.sv
// Bench: an 11011 Moore detector feeds the hit logger; expected indices go through a scoreboard queue.
module tb_seq_detect_hit_logger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din = 1'b0;
  logic       hit_frc = 1'b0;
  logic       clr = 1'b0;
  logic       rd_en = 1'b0;
  logic       hit;
  logic [4:0] det_sr;

  logic [7:0] rd_data;
  logic       empty, full, ovf;
  logic [2:0] level;
  logic [7:0] hit_cnt;

  logic [3:0] rd_data4;
  logic       empty4, full4, ovf4;
  logic [2:0] level4;
  logic [3:0] hit_cnt4;

  int         n_tests = 0;
  int         n_fail = 0;
  int         bit_n = 0;
  logic [4:0] hist = '0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) det_sr <= '0;
    else        det_sr <= {det_sr[3:0], din};
  end
  assign hit = (det_sr == 5'b11011) | hit_frc;

  seq_detect_hit_logger #(.POS_W(8), .DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .clr(clr), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .level(level),
    .hit_cnt(hit_cnt), .ovf(ovf)
  );

  seq_detect_hit_logger #(.POS_W(4), .DEPTH(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .hit(hit), .clr(clr), .rd_en(rd_en),
    .rd_data(rd_data4), .empty(empty4), .full(full4), .level(level4),
    .hit_cnt(hit_cnt4), .ovf(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one serial bit; a hit seen this cycle logs index bit_n-1.
  task automatic send_bit(input logic b, input logic frc = 1'b0, input logic rd = 1'b0);
    din = b;
    hit_frc = frc;
    rd_en = rd;
    if (hist == 5'b11011 || frc) sb.push_back(8'(bit_n - 1));
    hist = {hist[3:0], b};
    bit_n++;
    tick();
    din = 1'b0;
    hit_frc = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic send_pat(input logic [31:0] pat, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(pat[i]);
  endtask

  task automatic do_clr();
    din = 1'b0;
    clr = 1'b1;
    hist = {hist[3:0], 1'b0};
    tick();
    clr = 1'b0;
    bit_n = 0;
    sb.delete();
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard has no expected entry, DUT empty=%0d", tag, empty);
      return;
    end
    e = sb.pop_front();
    if (empty !== 1'b0 || rd_data !== e) begin
      n_fail++;
      $display("FAIL %s: rd_data=%0d empty=%0d, expected %0d", tag, rd_data, empty, e);
    end
    n_tests++;
    if (rd_data4 !== e[3:0]) begin
      n_fail++;
      $display("FAIL %s_w4: rd_data=%0d, expected %0d", tag, rd_data4, e[3:0]);
    end
    send_bit(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({empty, full, level, hit_cnt, ovf, rd_data} !== {1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset: empty=%0d full=%0d level=%0d hit_cnt=%0d ovf=%0d rd_data=%0d, expected 1 0 0 0 0 0",
               empty, full, level, hit_cnt, ovf, rd_data);
    end
    rst_n = 1'b1;
    hist = '0;
    bit_n = 0;
    sb.delete();
  endtask

  task automatic test_single();
    send_pat(32'b11011, 5);
    send_bit(1'b0);
    n_tests++;
    if (level !== 3'd1 || hit_cnt !== 8'd1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL single: level=%0d hit_cnt=%0d ovf=%0d, expected 1 1 0", level, hit_cnt, ovf);
    end
    pop_check("single_pop");
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_empty: empty=%0d, expected 1", empty);
    end
  endtask

  task automatic test_overlap();
    do_clr();
    send_pat(32'b110110110, 9);
    n_tests++;
    if (level !== 3'd2 || hit_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL overlap: level=%0d hit_cnt=%0d, expected 2 2", level, hit_cnt);
    end
    pop_check("overlap_pop0");
    pop_check("overlap_pop1");
    n_tests++;
    if (empty !== 1'b1 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL overlap_empty: empty=%0d level=%0d, expected 1 0", empty, level);
    end
  endtask

  task automatic test_overflow();
    logic [17:0] pat;
    do_clr();
    pat = 18'b11_011_011_011_011_011_0;
    for (int i = 17; i >= 0; i--) begin
      send_bit(pat[i]);
      if (i == 3) begin
        n_tests++;
        if (full !== 1'b1 || ovf !== 1'b0 || level !== 3'd4) begin
          n_fail++;
          $display("FAIL ovf_full: full=%0d ovf=%0d level=%0d, expected 1 0 4", full, ovf, level);
        end
      end
    end
    n_tests++;
    if (full !== 1'b1 || ovf !== 1'b1 || level !== 3'd4 || hit_cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL ovf_drop: full=%0d ovf=%0d level=%0d hit_cnt=%0d, expected 1 1 4 5", full, ovf, level, hit_cnt);
    end
    void'(sb.pop_back());
    for (int i = 0; i < 4; i++) pop_check("ovf_pop");
    n_tests++;
    if (empty !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drained: empty=%0d ovf=%0d, expected 1 1", empty, ovf);
    end
  endtask

  task automatic test_full_push_pop();
    do_clr();
    send_pat(32'b11_011_011_011_011_0, 15);
    send_bit(1'b1);
    send_bit(1'b1);
    n_tests++;
    if (full !== 1'b1 || rd_data !== 8'd4) begin
      n_fail++;
      $display("FAIL fpp_pre: full=%0d rd_data=%0d, expected 1 4", full, rd_data);
    end
    void'(sb.pop_front());
    send_bit(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (level !== 3'd4 || full !== 1'b1 || ovf !== 1'b0 || hit_cnt !== 8'd5 || rd_data !== 8'd7) begin
      n_fail++;
      $display("FAIL fpp: level=%0d full=%0d ovf=%0d hit_cnt=%0d rd_data=%0d, expected 4 1 0 5 7",
               level, full, ovf, hit_cnt, rd_data);
    end
    for (int i = 0; i < 4; i++) pop_check("fpp_pop");
  endtask

  task automatic test_back_to_back();
    do_clr();
    repeat (3) send_bit(1'b0);
    send_bit(1'b0, 1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    n_tests++;
    if (level !== 3'd3 || hit_cnt !== 8'd3 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b: level=%0d hit_cnt=%0d empty=%0d, expected 3 3 0", level, hit_cnt, empty);
    end
    for (int i = 0; i < 3; i++) pop_check("b2b_pop");
  endtask

  task automatic test_saturate();
    do_clr();
    repeat (2) send_bit(1'b0);
    for (int i = 0; i < 260; i++) begin
      send_bit(1'b0, 1'b1, 1'b1);
      if (i == 253) begin
        n_tests++;
        if (hit_cnt !== 8'd254) begin
          n_fail++;
          $display("FAIL sat_pre: hit_cnt=%0d, expected 254", hit_cnt);
        end
      end
    end
    sb.delete();
    n_tests++;
    if (hit_cnt !== 8'hFF || hit_cnt4 !== 4'hF || level !== 3'd1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sat: hit_cnt=%0d hit_cnt4=%0d level=%0d ovf=%0d, expected 255 15 1 0",
               hit_cnt, hit_cnt4, level, ovf);
    end
  endtask

  task automatic test_wrap_clr();
    do_clr();
    send_pat(32'b11011011, 8);
    n_tests++;
    if (level !== 3'd1 || hit == 1'b0) begin
      n_fail++;
      $display("FAIL clr_setup: level=%0d hit=%0d, expected 1 1", level, hit);
    end
    do_clr();
    n_tests++;
    if (empty !== 1'b1 || level !== 3'd0 || hit_cnt !== 8'd0 || hit_cnt4 !== 4'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_hit: empty=%0d level=%0d hit_cnt=%0d hit_cnt4=%0d ovf=%0d, expected 1 0 0 0 0",
               empty, level, hit_cnt, hit_cnt4, ovf);
    end
    repeat (13) send_bit(1'b0);
    send_pat(32'b110110, 6);
    n_tests++;
    if (level4 !== 3'd1 || hit_cnt !== 8'd1 || rd_data4 !== 4'd1 || rd_data !== 8'd17) begin
      n_fail++;
      $display("FAIL wrap: level4=%0d hit_cnt=%0d rd_data4=%0d rd_data=%0d, expected 1 1 1 17",
               level4, hit_cnt, rd_data4, rd_data);
    end
    pop_check("wrap_pop");
  endtask

  task automatic test_async_reset();
    do_clr();
    send_pat(32'b11_011_011_011_011_0, 15);
    send_pat(32'b110, 3);
    void'(sb.pop_back());
    pop_check("arst_pop0");
    pop_check("arst_pop1");
    n_tests++;
    if (level !== 3'd2 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_setup: level=%0d ovf=%0d, expected 2 1", level, ovf);
    end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (empty !== 1'b1 || level !== 3'd0 || hit_cnt !== 8'd0 || ovf !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL arst: empty=%0d level=%0d hit_cnt=%0d ovf=%0d full=%0d, expected 1 0 0 0 0",
               empty, level, hit_cnt, ovf, full);
    end
    tick();
    rst_n = 1'b1;
    hist = '0;
    bit_n = 0;
    sb.delete();
    send_pat(32'b110110, 6);
    n_tests++;
    if (level !== 3'd1 || hit_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL arst_restart: level=%0d hit_cnt=%0d, expected 1 1", level, hit_cnt);
    end
    pop_check("arst_restart_pop");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_saturate();
    test_wrap_clr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
